// File: rtl/reservation_station_ls.sv
// In-order reservation station feeding the load/store unit: FIFO of issued memory ops,
// CDB tag snooping, and a dispatcher that sequences the Ready_to_uf / Done / Clear handshake.
module reservation_station_ls #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Issue_valid,
    output logic                     Issue_ready,
    input  logic [2:0]               Issue_op,
    input  logic [15:0]              Issue_Vj,
    input  logic [15:0]              Issue_Vk,
    input  logic [TAG_W-1:0]         Issue_Qj,
    input  logic [TAG_W-1:0]         Issue_Qk,
    input  logic [TAG_W-1:0]         Issue_tag,
    input  logic                     CDB_valid,
    input  logic [TAG_W-1:0]         CDB_tag,
    input  logic [15:0]              CDB_data,
    output logic [15:0]              A,
    output logic [15:0]              B,
    output logic [2:0]               Ufop,
    output logic                     Ready_to_uf,
    output logic                     Clear,
    output logic [TAG_W-1:0]         Exec_tag,
    input  logic                     Done,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state_q;

    logic               busy_q [DEPTH];
    logic [2:0]         op_q   [DEPTH];
    logic [15:0]        vj_q   [DEPTH];
    logic [15:0]        vk_q   [DEPTH];
    logic [TAG_W-1:0]   qj_q   [DEPTH];
    logic [TAG_W-1:0]   qk_q   [DEPTH];
    logic [TAG_W-1:0]   tag_q  [DEPTH];

    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    logic               cdb_live;
    logic               do_issue;
    logic               do_pop;
    logic               fwd_j;
    logic               fwd_k;
    logic               head_rdy;

    // Tag 0 means "value present", so a broadcast of tag 0 must never resolve anything.
    assign cdb_live    = CDB_valid && (CDB_tag != '0);
    assign Issue_ready = (count_q < CNT_W'(DEPTH));
    assign Count       = count_q;
    assign do_issue    = Issue_valid && Issue_ready;
    assign do_pop      = (state_q == S_EXEC) && Done;
    assign fwd_j       = cdb_live && (Issue_Qj == CDB_tag);
    assign fwd_k       = cdb_live && (Issue_Qk == CDB_tag);
    assign head_rdy    = busy_q[head_q] && (qj_q[head_q] == '0) && (qk_q[head_q] == '0);

    // Entry storage, pointers and occupancy; the issued slot is never busy, so snoop and issue never collide.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                busy_q[i] <= 1'b0;
                op_q[i]   <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && cdb_live) begin
                    if (qj_q[i] == CDB_tag) begin
                        vj_q[i] <= CDB_data;
                        qj_q[i] <= '0;
                    end
                    if (qk_q[i] == CDB_tag) begin
                        vk_q[i] <= CDB_data;
                        qk_q[i] <= '0;
                    end
                end
            end

            if (do_pop) begin
                busy_q[head_q] <= 1'b0;
                head_q         <= head_q + PTR_W'(1);
            end

            if (do_issue) begin
                busy_q[tail_q] <= 1'b1;
                op_q[tail_q]   <= Issue_op;
                tag_q[tail_q]  <= Issue_tag;
                vj_q[tail_q]   <= fwd_j ? CDB_data : Issue_Vj;
                vk_q[tail_q]   <= fwd_k ? CDB_data : Issue_Vk;
                qj_q[tail_q]   <= fwd_j ? '0 : Issue_Qj;
                qk_q[tail_q]   <= fwd_k ? '0 : Issue_Qk;
                tail_q         <= tail_q + PTR_W'(1);
            end

            case ({do_issue, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Dispatcher: only the FIFO head may go to the unit, which keeps loads and stores in program order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            A           <= '0;
            B           <= '0;
            Ufop        <= '0;
            Exec_tag    <= '0;
            Ready_to_uf <= 1'b0;
            Clear       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    Clear <= 1'b0;
                    if (head_rdy) begin
                        A           <= vj_q[head_q];
                        B           <= vk_q[head_q];
                        Ufop        <= op_q[head_q];
                        Exec_tag    <= tag_q[head_q];
                        Ready_to_uf <= 1'b1;
                        state_q     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (Done) begin
                        Ready_to_uf <= 1'b0;
                        Clear       <= 1'b1;
                        state_q     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    Clear   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    Ready_to_uf <= 1'b0;
                    Clear       <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reservation_station_ls.sv
// Directed bench for reservation_station_ls with a small load/store unit model
// that raises Done two edges after Ready_to_uf rises (optionally held off).
module tb_reservation_station_ls;

    logic        Clock;
    logic        Reset;
    logic        Issue_valid;
    logic        Issue_ready;
    logic [2:0]  Issue_op;
    logic [15:0] Issue_Vj;
    logic [15:0] Issue_Vk;
    logic [2:0]  Issue_Qj;
    logic [2:0]  Issue_Qk;
    logic [2:0]  Issue_tag;
    logic        CDB_valid;
    logic [2:0]  CDB_tag;
    logic [15:0] CDB_data;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  Ufop;
    logic        Ready_to_uf;
    logic        Clear;
    logic [2:0]  Exec_tag;
    logic        Done;
    logic [2:0]  Count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] step;
    bit         hold_done = 1'b0;

    reservation_station_ls #(.DEPTH(4), .TAG_W(3)) dut (
        .Clock(Clock), .Reset(Reset),
        .Issue_valid(Issue_valid), .Issue_ready(Issue_ready), .Issue_op(Issue_op),
        .Issue_Vj(Issue_Vj), .Issue_Vk(Issue_Vk), .Issue_Qj(Issue_Qj), .Issue_Qk(Issue_Qk),
        .Issue_tag(Issue_tag), .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
        .A(A), .B(B), .Ufop(Ufop), .Ready_to_uf(Ready_to_uf), .Clear(Clear),
        .Exec_tag(Exec_tag), .Done(Done), .Count(Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Unit model: step counter reset by Clear, Done once two steps have elapsed.
    always @(posedge Clock or posedge Reset) begin
        if (Reset)                               step <= 2'd0;
        else if (Clear)                          step <= 2'd0;
        else if (Ready_to_uf && step != 2'd2)    step <= step + 2'd1;
    end
    assign Done = Ready_to_uf && (step == 2'd2) && !hold_done;

    task automatic do_issue(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                            input logic [2:0] qj, input logic [2:0] qk, input logic [2:0] tag);
        Issue_valid = 1'b1; Issue_op = op; Issue_Vj = vj; Issue_Vk = vk;
        Issue_Qj = qj; Issue_Qk = qk; Issue_tag = tag;
        @(negedge Clock);
        Issue_valid = 1'b0;
    endtask

    task automatic wait_dispatch(output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (!ok && cyc < 20) begin
            if (Ready_to_uf === 1'b1) ok = 1'b1;
            else begin @(negedge Clock); cyc++; end
        end
    endtask

    task automatic wait_clear(output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (!ok && cyc < 20) begin
            if (Clear === 1'b1) ok = 1'b1;
            else begin @(negedge Clock); cyc++; end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        n_cmp++; if (Count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", Count); end
        n_cmp++; if (Issue_ready !== 1'b1) begin n_bad++; $display("FAIL reset_issue_ready got=%b exp=1", Issue_ready); end
        n_cmp++; if (Ready_to_uf !== 1'b0) begin n_bad++; $display("FAIL reset_ready_to_uf got=%b exp=0", Ready_to_uf); end
        n_cmp++; if (Clear !== 1'b0) begin n_bad++; $display("FAIL reset_clear got=%b exp=0", Clear); end
        n_cmp++; if ({A, B, Ufop, Exec_tag} !== 38'd0) begin n_bad++; $display("FAIL reset_outputs got A=%h B=%h op=%0d tag=%0d exp all 0", A, B, Ufop, Exec_tag); end
        Reset = 1'b0;
        @(negedge Clock);
        n_cmp++; if (Ready_to_uf !== 1'b0) begin n_bad++; $display("FAIL reset_idle got=%b exp=0", Ready_to_uf); end
    endtask

    task automatic test_basic_load;
        int cyc; bit ok;
        do_issue(3'd4, 16'd3, 16'd2, 3'd0, 3'd0, 3'd5);
        n_cmp++; if (Count !== 3'd1) begin n_bad++; $display("FAIL basic_count1 got=%0d exp=1", Count); end
        n_cmp++; if (Ready_to_uf !== 1'b0) begin n_bad++; $display("FAIL basic_early got=%b exp=0", Ready_to_uf); end
        @(negedge Clock);
        n_cmp++; if (Ready_to_uf !== 1'b1) begin n_bad++; $display("FAIL basic_dispatch got=%b exp=1", Ready_to_uf); end
        n_cmp++; if ({A, B, Ufop, Exec_tag} !== {16'd3, 16'd2, 3'd4, 3'd5}) begin n_bad++; $display("FAIL basic_operands got A=%h B=%h op=%0d tag=%0d exp 3 2 4 5", A, B, Ufop, Exec_tag); end
        wait_clear(cyc, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_clear_timeout got=none exp=Clear"); end
        n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL basic_done_latency got=%0d exp=3", cyc); end
        n_cmp++; if (Count !== 3'd0) begin n_bad++; $display("FAIL basic_count0 got=%0d exp=0", Count); end
        n_cmp++; if (Ready_to_uf !== 1'b0) begin n_bad++; $display("FAIL basic_ready_drop got=%b exp=0", Ready_to_uf); end
        @(negedge Clock);
        n_cmp++; if (Clear !== 1'b0) begin n_bad++; $display("FAIL basic_clear_pulse got=%b exp=0", Clear); end
    endtask

    task automatic test_cdb_resolve;
        int cyc; bit ok;
        do_issue(3'd5, 16'h0000, 16'h0001, 3'd2, 3'd0, 3'd1);
        repeat (2) begin
            @(negedge Clock);
            n_cmp++; if (Ready_to_uf !== 1'b0) begin n_bad++; $display("FAIL cdb_no_early_dispatch got=%b exp=0", Ready_to_uf); end
        end
        CDB_valid = 1'b1; CDB_tag = 3'd2; CDB_data = 16'h0010;
        @(negedge Clock);
        CDB_valid = 1'b0;
        n_cmp++; if (Ready_to_uf !== 1'b0) begin n_bad++; $display("FAIL cdb_same_edge got=%b exp=0", Ready_to_uf); end
        @(negedge Clock);
        n_cmp++; if (Ready_to_uf !== 1'b1) begin n_bad++; $display("FAIL cdb_dispatch got=%b exp=1", Ready_to_uf); end
        n_cmp++; if ({A, B, Ufop, Exec_tag} !== {16'h0010, 16'h0001, 3'd5, 3'd1}) begin n_bad++; $display("FAIL cdb_operands got A=%h B=%h op=%0d tag=%0d exp 0010 0001 5 1", A, B, Ufop, Exec_tag); end
        wait_clear(cyc, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL cdb_clear_timeout got=none exp=Clear"); end
        @(negedge Clock);
    endtask

    task automatic test_issue_forward;
        int cyc; bit ok;
        CDB_valid = 1'b1; CDB_tag = 3'd3; CDB_data = 16'hBEEF;
        do_issue(3'd4, 16'd7, 16'd0, 3'd0, 3'd3, 3'd2);
        CDB_valid = 1'b0;
        n_cmp++; if (Count !== 3'd1) begin n_bad++; $display("FAIL fwd_count got=%0d exp=1", Count); end
        @(negedge Clock);
        n_cmp++; if (Ready_to_uf !== 1'b1) begin n_bad++; $display("FAIL fwd_dispatch got=%b exp=1", Ready_to_uf); end
        n_cmp++; if ({A, B} !== {16'd7, 16'hBEEF}) begin n_bad++; $display("FAIL fwd_operands got A=%h B=%h exp 0007 beef", A, B); end
        wait_clear(cyc, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fwd_clear_timeout got=none exp=Clear"); end
        @(negedge Clock);
    endtask

    task automatic test_full_blocked;
        int cyc; bit ok;
        logic [2:0]  exp_tag [4];
        logic [15:0] exp_a   [4];
        exp_tag = '{3'd1, 3'd2, 3'd3, 3'd4};
        exp_a   = '{16'h0077, 16'h0020, 16'h0030, 16'h0040};
        do_issue(3'd4, 16'h0000, 16'd1, 3'd7, 3'd0, 3'd1);
        do_issue(3'd5, 16'h0020, 16'd2, 3'd0, 3'd0, 3'd2);
        do_issue(3'd4, 16'h0030, 16'd3, 3'd0, 3'd0, 3'd3);
        do_issue(3'd0, 16'h0040, 16'd4, 3'd0, 3'd0, 3'd4);
        n_cmp++; if (Count !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d exp=4", Count); end
        n_cmp++; if (Issue_ready !== 1'b0) begin n_bad++; $display("FAIL full_issue_ready got=%b exp=0", Issue_ready); end
        do_issue(3'd4, 16'h0060, 16'd6, 3'd0, 3'd0, 3'd6);
        n_cmp++; if (Count !== 3'd4) begin n_bad++; $display("FAIL full_ignored got=%0d exp=4", Count); end
        n_cmp++; if (Ready_to_uf !== 1'b0) begin n_bad++; $display("FAIL full_no_bypass got=%b exp=0", Ready_to_uf); end
        CDB_valid = 1'b1; CDB_tag = 3'd7; CDB_data = 16'h0077;
        @(negedge Clock);
        CDB_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_dispatch(cyc, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_dispatch_timeout k=%0d got=none exp=dispatch", k); end
            n_cmp++; if (Exec_tag !== exp_tag[k]) begin n_bad++; $display("FAIL full_order k=%0d got=%0d exp=%0d", k, Exec_tag, exp_tag[k]); end
            n_cmp++; if (A !== exp_a[k]) begin n_bad++; $display("FAIL full_a k=%0d got=%h exp=%h", k, A, exp_a[k]); end
            if (k > 0) begin
                n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL full_spacing k=%0d got=%0d exp=2", k, cyc); end
            end
            wait_clear(cyc, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_clear_timeout k=%0d got=none exp=Clear", k); end
        end
        @(negedge Clock);
        n_cmp++; if (Count !== 3'd0) begin n_bad++; $display("FAIL full_drained got=%0d exp=0", Count); end
    endtask

    task automatic test_pop_issue_wrap;
        int cyc; bit ok;
        logic [2:0] exp_tag;
        hold_done = 1'b1;
        for (int t = 1; t <= 4; t++) do_issue(3'd4, 16'(t * 16), 16'd0, 3'd0, 3'd0, 3'(t));
        n_cmp++; if (Count !== 3'd4) begin n_bad++; $display("FAIL wrap_full got=%0d exp=4", Count); end
        n_cmp++; if (Exec_tag !== 3'd1) begin n_bad++; $display("FAIL wrap_head got=%0d exp=1", Exec_tag); end
        hold_done = 1'b0;
        Issue_valid = 1'b1; Issue_op = 3'd4; Issue_Vj = 16'h0050; Issue_Vk = 16'd0;
        Issue_Qj = 3'd0; Issue_Qk = 3'd0; Issue_tag = 3'd5;
        @(negedge Clock);
        n_cmp++; if ({Clear, Count, Issue_ready} !== {1'b1, 3'd3, 1'b1}) begin n_bad++; $display("FAIL wrap_pop_at_full got clr=%b cnt=%0d rdy=%b exp 1 3 1", Clear, Count, Issue_ready); end
        @(negedge Clock);
        Issue_valid = 1'b0;
        n_cmp++; if ({Clear, Count} !== {1'b0, 3'd4}) begin n_bad++; $display("FAIL wrap_refill got clr=%b cnt=%0d exp 0 4", Clear, Count); end
        wait_dispatch(cyc, ok);
        n_cmp++; if (!ok || Exec_tag !== 3'd2 || A !== 16'h0020) begin n_bad++; $display("FAIL wrap_tag2 got ok=%b tag=%0d A=%h exp 1 2 0020", ok, Exec_tag, A); end
        wait_clear(cyc, ok);
        n_cmp++; if (!ok || Count !== 3'd3) begin n_bad++; $display("FAIL wrap_pop2 got ok=%b cnt=%0d exp 1 3", ok, Count); end
        wait_dispatch(cyc, ok);
        hold_done = 1'b1;
        n_cmp++; if (!ok || Exec_tag !== 3'd3) begin n_bad++; $display("FAIL wrap_tag3 got ok=%b tag=%0d exp 1 3", ok, Exec_tag); end
        repeat (3) @(negedge Clock);
        n_cmp++; if ({Ready_to_uf, Clear} !== 2'b10) begin n_bad++; $display("FAIL wrap_hold got rdy=%b clr=%b exp 1 0", Ready_to_uf, Clear); end
        hold_done = 1'b0;
        do_issue(3'd4, 16'h0060, 16'd0, 3'd0, 3'd0, 3'd6);
        n_cmp++; if ({Clear, Count} !== {1'b1, 3'd3}) begin n_bad++; $display("FAIL wrap_pop_and_issue got clr=%b cnt=%0d exp 1 3", Clear, Count); end
        for (int k = 4; k <= 6; k++) begin
            exp_tag = 3'(k);
            wait_dispatch(cyc, ok);
            n_cmp++; if (!ok || Exec_tag !== exp_tag || A !== 16'(k * 16)) begin n_bad++; $display("FAIL wrap_order got ok=%b tag=%0d A=%h exp tag=%0d", ok, Exec_tag, A, exp_tag); end
            wait_clear(cyc, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_clear_timeout k=%0d got=none exp=Clear", k); end
        end
        @(negedge Clock);
        n_cmp++; if ({Count, Issue_ready} !== {3'd0, 1'b1}) begin n_bad++; $display("FAIL wrap_empty got cnt=%0d rdy=%b exp 0 1", Count, Issue_ready); end
    endtask

    task automatic test_reset_in_exec;
        int cyc; bit ok;
        do_issue(3'd4, 16'h0055, 16'h0066, 3'd0, 3'd0, 3'd2);
        wait_dispatch(cyc, ok);
        hold_done = 1'b1;
        n_cmp++; if (!ok || A !== 16'h0055) begin n_bad++; $display("FAIL rexec_dispatch got ok=%b A=%h exp 1 0055", ok, A); end
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        #1;
        n_cmp++; if ({Ready_to_uf, Clear, Count} !== 5'd0) begin n_bad++; $display("FAIL rexec_ctrl got rdy=%b clr=%b cnt=%0d exp 0 0 0", Ready_to_uf, Clear, Count); end
        n_cmp++; if ({A, B, Ufop, Exec_tag} !== 38'd0) begin n_bad++; $display("FAIL rexec_outputs got A=%h B=%h op=%0d tag=%0d exp all 0", A, B, Ufop, Exec_tag); end
        n_cmp++; if (Issue_ready !== 1'b1) begin n_bad++; $display("FAIL rexec_issue_ready got=%b exp=1", Issue_ready); end
        @(negedge Clock);
        Reset = 1'b0;
        hold_done = 1'b0;
        do_issue(3'd5, 16'd9, 16'd1, 3'd0, 3'd0, 3'd3);
        @(negedge Clock);
        n_cmp++; if ({Ready_to_uf, A, B, Ufop, Exec_tag} !== {1'b1, 16'd9, 16'd1, 3'd5, 3'd3}) begin n_bad++; $display("FAIL rexec_after got rdy=%b A=%h B=%h op=%0d tag=%0d exp 1 0009 0001 5 3", Ready_to_uf, A, B, Ufop, Exec_tag); end
        wait_clear(cyc, ok);
        n_cmp++; if (!ok || Count !== 3'd0) begin n_bad++; $display("FAIL rexec_drain got ok=%b cnt=%0d exp 1 0", ok, Count); end
    endtask

    initial begin
        Reset = 1'b1; Issue_valid = 1'b0; Issue_op = '0; Issue_Vj = '0; Issue_Vk = '0;
        Issue_Qj = '0; Issue_Qk = '0; Issue_tag = '0;
        CDB_valid = 1'b0; CDB_tag = '0; CDB_data = '0;
        test_reset;
        test_basic_load;
        test_cdb_resolve;
        test_issue_forward;
        test_full_blocked;
        test_pop_issue_wrap;
        test_reset_in_exec;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reservation_station_ls.md
# reservation_station_ls

In-order reservation station for the load/store functional unit, placed directly upstream of it in the Tomasulo datapath. It accepts issued memory ops with operand values or producer tags, snoops the CDB to resolve pending tags, and dispatches the FIFO head to the unit once both operands are resolved. It sequences the unit's Ready_to_uf / Done / Clear handshake and frees the entry on completion. Strict FIFO dispatch preserves program order between loads and stores.

## Interface
- DEPTH, 4: entries; power of two, 2..8
- TAG_W, 3: producer tag width; tag 0 = "value present"
- Clock  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Issue_valid  in  1  issue request this cycle
- Issue_ready  out  1  entry free (count < DEPTH)
- Issue_op  in  3  Ufop code: 0 NOP, 4 load, 5 store
- Issue_Vj, Issue_Vk  in  16 each  operand values (base, offset)
- Issue_Qj, Issue_Qk  in  TAG_W each  producer tags; 0 = operand valid
- Issue_tag  in  TAG_W  destination tag of this op
- CDB_valid  in  1  broadcast valid
- CDB_tag  in  TAG_W  broadcast tag
- CDB_data  in  16  broadcast value
- A, B  out  16 each  operands to unit
- Ufop  out  3  op to unit
- Ready_to_uf  out  1  held high for the whole execution
- Clear  out  1  one-cycle pulse resetting unit step counter
- Exec_tag  out  TAG_W  destination tag of op in execution
- Done  in  1  unit completion
- Count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: circular FIFO, head/tail pointers wrap modulo DEPTH; per entry Busy, Op, Vj, Vk, Qj, Qk, Tag.
- Issue: Issue_valid && Issue_ready writes tail, tail+1. Issue_valid while full ignored, no state change.
- Issue_ready from registered count only; no same-cycle bypass of a pop.
- CDB snoop, every cycle, all busy entries: Qj==CDB_tag (nonzero) sets Vj=CDB_data, Qj=0; same for k independently; both may match.
- Issue-cycle forwarding: issued Qj/Qk equal to a valid CDB_tag stored as resolved with CDB_data.
- CDB_tag 0 never matches.
- Dispatcher FSM:
  - IDLE: head busy && Qj==0 && Qk==0 (registered) -> load A=Vj, B=Vk, Ufop=Op, Exec_tag=Tag, Ready_to_uf=1; go EXEC. Otherwise wait.
  - EXEC: hold outputs stable; Done==1 -> Ready_to_uf=0, Clear=1, pop head, count-1; go RELEASE.
  - RELEASE: Clear=0; go IDLE.
- NOP entries dispatch like any op (unit returns Done at step 1).
- Non-head entries never dispatch even if ready.
- Simultaneous issue and pop: both apply; count unchanged.
- Reset (any time, incl. EXEC): FSM IDLE, entries invalid, pointers 0, Count 0, Issue_ready 1; A, B, Ufop, Exec_tag, Ready_to_uf, Clear all 0. Unit reset externally by same Reset.

## Timing
- Issue at edge N with operands valid: Ready_to_uf high after edge N+1.
- Operand resolved by CDB at edge N: dispatch earliest edge N+1.
- Unit asserts Done two edges after Ready_to_uf rises; Clear pulses after the Done edge; next dispatch earliest two edges after Clear rises.
- Back-to-back ready ops: one dispatch per 5 cycles.
- All outputs registered except Issue_ready and Count (from registered count).

## Test plan
- Reset then issue load Vj=3, Vk=2, Qj=Qk=0, tag 5 -> Ready_to_uf=1, A=3, B=2, Ufop=4, Exec_tag=5 after one edge; Done -> Clear pulse, Count 1->0.
- Issue store Qj=2, Vk=1; CDB tag 2 data 0x0010 two cycles later -> no dispatch before broadcast; next cycle A=0x0010, B=1, Ufop=5.
- Issue with Qk=3 in same cycle as CDB tag 3 data 0xBEEF -> entry stored resolved, B=0xBEEF at dispatch.
- Fill DEPTH=4 entries, head blocked on tag 7 -> Issue_ready=0, 5th issue ignored, Count=4; ready entries 1-3 do not dispatch; CDB tag 7 -> drain in order, tags in issue order.
- Pop and issue in same cycle at full, plus pointer wrap over 6 issues -> Count correct, FIFO order preserved.
- Reset asserted during EXEC -> Ready_to_uf, Clear, Count, A, B, Ufop 0 immediately; later issue works normally.
